// File: rtl/fft_sequencer.sv
// Frame controller for the in-place fft datapath: loads N samples by address,
// waits for completion, buffers the N-bin result and drains it as a stream.
module fft_sequencer #(
    parameter int N       = 16,
    parameter int MSB     = 16,
    parameter int BIT_REV = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MSB-1:0]       s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [MSB-1:0]       fft_data_in,
    output logic [$clog2(N)-1:0] fft_addr,
    output logic                 fft_insert_data,
    input  logic [MSB*N-1:0]     fft_data_out,
    input  logic                 fft_finish,
    output logic [MSB-1:0]       m_data,
    output logic [$clog2(N)-1:0] m_index,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          frame_cnt
);
    localparam int AW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_cnt_reg, wr_cnt_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            s_ready_reg;
    logic [MSB-1:0]  data_in_reg, data_in_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic            insert_reg, insert_next;
    logic            timeout_reg, timeout_next;
    logic [15:0]     frame_cnt_reg, frame_cnt_next;
    logic            full_reg, full_next;
    logic [AW-1:0]   rd_cnt_reg, rd_cnt_next;
    logic            capture;
    logic            accept;
    logic [AW-1:0]   rev_idx;
    logic [AW-1:0]   rd_idx;
    logic [MSB-1:0]  buf_mem [N];

    assign accept = s_ready_reg & s_valid;

    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        timer_next     = timer_reg;
        data_in_next   = data_in_reg;
        addr_next      = addr_reg;
        insert_next    = insert_reg;
        timeout_next   = timeout_reg;
        frame_cnt_next = frame_cnt_reg;
        full_next      = full_reg;
        rd_cnt_next    = rd_cnt_reg;
        capture        = 1'b0;

        if (full_reg && m_ready) begin
            if (rd_cnt_reg == AW'(N - 1)) begin
                rd_cnt_next = '0;
                full_next   = 1'b0;
            end else begin
                rd_cnt_next = rd_cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                insert_next = accept;
                if (accept) begin
                    data_in_next = s_data;
                    addr_next    = '0;
                    wr_cnt_next  = AW'(1);
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                // Strobe stays high across input stalls; the held pair is rewritten harmlessly.
                insert_next = 1'b1;
                if (accept) begin
                    data_in_next = s_data;
                    addr_next    = wr_cnt_reg;
                    if (wr_cnt_reg == AW'(N - 1)) begin
                        wr_cnt_next = '0;
                        timer_next  = '0;
                        state_next  = CALC;
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 1'b1;
                    end
                end
            end
            CALC: begin
                insert_next = 1'b0;
                timer_next  = timer_reg + 1'b1;
                if (fft_finish) begin
                    state_next = HOLD;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            HOLD: begin
                insert_next = 1'b0;
                // Registered full flag: a last-bin drain this cycle defers capture by one.
                if (!full_reg) begin
                    capture        = 1'b1;
                    full_next      = 1'b1;
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_cnt_reg    <= '0;
            timer_reg     <= '0;
            s_ready_reg   <= 1'b0;
            data_in_reg   <= '0;
            addr_reg      <= '0;
            insert_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            full_reg      <= 1'b0;
            rd_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            timer_reg     <= timer_next;
            s_ready_reg   <= (state_next == IDLE) || (state_next == LOAD);
            data_in_reg   <= data_in_next;
            addr_reg      <= addr_next;
            insert_reg    <= insert_next;
            timeout_reg   <= timeout_next;
            frame_cnt_reg <= frame_cnt_next;
            full_reg      <= full_next;
            rd_cnt_reg    <= rd_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                buf_mem[i] <= fft_data_out[MSB*i +: MSB];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_rev
            assign rev_idx[gi] = rd_cnt_reg[AW-1-gi];
        end
    endgenerate

    assign rd_idx          = (BIT_REV != 0) ? rev_idx : rd_cnt_reg;
    assign m_data          = full_reg ? buf_mem[rd_idx] : '0;
    assign m_index         = rd_cnt_reg;
    assign m_last          = full_reg && (rd_cnt_reg == AW'(N - 1));
    assign m_valid         = full_reg;
    assign s_ready         = s_ready_reg;
    assign fft_data_in     = data_in_reg;
    assign fft_addr        = addr_reg;
    assign fft_insert_data = insert_reg;
    assign busy            = (state_reg != IDLE);
    assign timeout_err     = timeout_reg;
    assign frame_cnt       = frame_cnt_reg;
endmodule

// File: tb/tb_fft_sequencer.sv
// Cycle-stepped bench for fft_sequencer: acts as the fft datapath and checks
// load writes and drained bins against a frame-level reference model.
module tb_fft_sequencer;
    localparam int N       = 16;
    localparam int MSB     = 16;
    localparam int AW      = 4;
    localparam int BIT_REV = 1;
    localparam int TIMEOUT = 60;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [MSB-1:0]     s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [MSB-1:0]     fft_data_in;
    logic [AW-1:0]      fft_addr;
    logic               fft_insert_data;
    logic [MSB*N-1:0]   fft_data_out = '0;
    logic               fft_finish = 1'b0;
    logic [MSB-1:0]     m_data;
    logic [AW-1:0]      m_index;
    logic               m_last;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               busy;
    logic               timeout_err;
    logic [15:0]        frame_cnt;

    always #5 clk = ~clk;

    fft_sequencer #(.N(N), .MSB(MSB), .BIT_REV(BIT_REV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fft_data_in(fft_data_in), .fft_addr(fft_addr), .fft_insert_data(fft_insert_data),
        .fft_data_out(fft_data_out), .fft_finish(fft_finish),
        .m_data(m_data), .m_index(m_index), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [MSB-1:0] data;
        int             idx;
        bit             last;
    } bin_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [MSB-1:0] dp_mem [N];
    bin_t           exp_q[$];
    int             acc_cnt = 0;
    bit             presented_last = 0;
    int             wr_idx_exp = 0;
    logic [MSB-1:0] wr_data_exp = '0;
    bit             in_calc = 0;
    int             calc_cycles = 0;
    int             fin_delay = 10;
    int             fin_delay_cfg = 0;
    bit             no_finish = 0;
    bit             exp_timeout = 0;
    int             finish_cnt = 0;
    int             frames_left = 0;
    int             s_valid_pct = 100;
    int             m_ready_pct = 100;
    int             bubble_at = -1;
    int             bubble_cnt = 0;
    bit             stray_finish = 0;
    int             drained = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        int x = v;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [MSB-1:0] bin_value(input int k);
        return dp_mem[k] + MSB'(k * 257);
    endfunction

    task automatic tick();
        bit   acc;
        bit   drn;
        bit   ins_exp;
        bin_t f;
        @(negedge clk);
        ins_exp = (acc_cnt > 0) || presented_last;
        if (fft_insert_data) dp_mem[fft_addr] = fft_data_in;
        check("fft_insert_data", 32'(fft_insert_data), 32'(ins_exp));
        if (ins_exp) begin
            check("fft_addr", 32'(fft_addr), 32'(wr_idx_exp));
            check("fft_data_in", 32'(fft_data_in), 32'(wr_data_exp));
        end

        fft_finish = 1'b0;
        if (stray_finish) begin
            fft_finish = 1'b1;
            stray_finish = 0;
        end
        if (in_calc) begin
            calc_cycles++;
            if (no_finish && calc_cycles == TIMEOUT + 1) begin
                exp_timeout = 1;
                in_calc = 0;
                check("s_ready_after_timeout", 32'(s_ready), 32'd1);
                check("busy_after_timeout", 32'(busy), 32'd0);
            end else begin
                check("s_ready_calc", 32'(s_ready), 32'd0);
                check("busy_calc", 32'(busy), 32'd1);
                if (!no_finish && calc_cycles == fin_delay) begin
                    for (int i = 0; i < N; i++) fft_data_out[MSB*i +: MSB] = bin_value(i);
                    for (int i = 0; i < N; i++) begin
                        f.data = bin_value(bitrev(i));
                        f.idx  = i;
                        f.last = (i == N - 1);
                        exp_q.push_back(f);
                    end
                    fft_finish = 1'b1;
                    in_calc = 0;
                    finish_cnt++;
                end
            end
        end
        check("timeout_err", 32'(timeout_err), 32'(exp_timeout));

        s_valid = (frames_left > 0) && (bubble_cnt == 0) && ($urandom_range(1, 100) <= s_valid_pct);
        if (bubble_cnt > 0) bubble_cnt--;
        s_data  = MSB'($urandom);
        m_ready = ($urandom_range(1, 100) <= m_ready_pct);

        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("m_valid_unexpected", 32'(m_valid), 32'd0);
            end else begin
                f = exp_q[0];
                check("m_data", 32'(m_data), 32'(f.data));
                check("m_index", 32'(m_index), 32'(f.idx));
                check("m_last", 32'(m_last), 32'(f.last));
            end
        end

        acc = s_valid && s_ready;
        drn = m_valid && m_ready;
        @(posedge clk);
        presented_last = 0;
        if (acc) begin
            wr_idx_exp  = acc_cnt;
            wr_data_exp = s_data;
            if (acc_cnt == bubble_at) bubble_cnt = 3;
            acc_cnt++;
            if (acc_cnt == N) begin
                acc_cnt = 0;
                presented_last = 1;
                in_calc = 1;
                calc_cycles = 0;
                fin_delay = (fin_delay_cfg > 0) ? fin_delay_cfg : int'($urandom_range(3, 50));
                frames_left--;
            end
        end
        if (drn && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            drained++;
        end
        #1;
    endtask

    task automatic run_frames(input int n, input int budget);
        int cyc = 0;
        bit ok;
        frames_left = n;
        while ((frames_left > 0 || in_calc || exp_q.size() > 0) && cyc < budget) begin
            tick();
            cyc++;
        end
        ok = (cyc < budget);
        check("cycle_budget", 32'(ok), 32'd1);
        tick();
        tick();
        check("m_valid_after_drain", 32'(m_valid), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(finish_cnt[15:0]));
        $display("frames done: n=%0d cycles=%0d frame_cnt=%0d", n, cyc, frame_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        fft_finish = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_insert", 32'(fft_insert_data), 32'd0);
        check("rst_addr", 32'(fft_addr), 32'd0);
        check("rst_data_in", 32'(fft_data_in), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_index", 32'(m_index), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        acc_cnt = 0;
        presented_last = 0;
        in_calc = 0;
        exp_timeout = 0;
        finish_cnt = 0;
        frames_left = 0;
        bubble_cnt = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", 32'(s_ready), 32'd1);
        $display("reset applied: s_ready=%0d busy=%0d", s_ready, busy);
    endtask

    initial begin
        bit seen;
        int cyc;

        // Reset and a stray completion pulse while idle
        do_reset();
        stray_finish = 1;
        tick();
        tick();
        check("stray_finish_frame_cnt", 32'(frame_cnt), 32'd0);
        check("stray_finish_m_valid", 32'(m_valid), 32'd0);
        check("stray_finish_busy", 32'(busy), 32'd0);

        // Single continuous frame
        s_valid_pct = 100; m_ready_pct = 100; fin_delay_cfg = 40;
        run_frames(1, 500);

        // Input bubbles after sample 5
        bubble_at = 5;
        run_frames(1, 500);
        bubble_at = -1;

        // Back-to-back frames: draining overlaps loading
        fin_delay_cfg = 5;
        run_frames(3, 1000);

        // Randomized valid/ready and completion latency
        s_valid_pct = 70; m_ready_pct = 60; fin_delay_cfg = 0;
        run_frames(6, 4000);

        // Back-pressure: frame 2 finishes while frame 1 is undrained
        s_valid_pct = 100; m_ready_pct = 0; fin_delay_cfg = 10;
        frames_left = 2;
        cyc = 0;
        while ((frames_left > 0 || in_calc) && cyc < 400) begin
            tick();
            cyc++;
        end
        check("hold_budget", 32'(cyc < 400), 32'd1);
        repeat (20) tick();
        check("hold_s_ready", 32'(s_ready), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_m_valid", 32'(m_valid), 32'd1);
        check("hold_m_index", 32'(m_index), 32'd0);
        check("hold_frame_cnt", 32'(frame_cnt), 32'(finish_cnt - 1));
        m_ready_pct = 100;
        run_frames(0, 500);

        // Timeout with no completion pulse
        no_finish = 1;
        run_frames(1, 500);
        no_finish = 0;
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        run_frames(1, 500);

        // Reset in the middle of a drain
        m_ready_pct = 0; fin_delay_cfg = 8;
        frames_left = 1;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 400) begin
            tick();
            seen = m_valid;
            cyc++;
        end
        check("drain_start", 32'(seen), 32'd1);
        m_ready_pct = 100;
        drained = 0;
        repeat (8) tick();
        check("drained_before_reset", 32'(drained), 32'd8);
        do_reset();
        m_ready_pct = 100;
        repeat (5) tick();
        check("m_valid_after_reset", 32'(m_valid), 32'd0);
        run_frames(1, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
